ram_controller: RTL and testbench
=================================

# ram_controller

Bus-initiator for the CPU's 16×8 RAM: accepts single or burst read/write requests from the control unit over a valid/ready handshake and sequences the RAM's address, bidirectional data bus, active-high write enable and active-low output enable. It sits between the control sequencer and the `ram` block and owns the data-bus turnaround, so no other block drives the RAM pins.

## Interface

- `ADDR_W`, 4, RAM address width (16 words).
- `DATA_W`, 8, data word width.

- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request; high only in IDLE.
- `req_write`  in  1  1 = write burst, 0 = read burst.
- `req_addr`  in  ADDR_W  start address.
- `req_len`  in  ADDR_W  beats minus one (0 → 1 beat, 15 → 16 beats).
- `wr_data`  in  DATA_W  write beat data.
- `wr_valid`  in  1  write beat present.
- `wr_ready`  out  1  write beat accepted this cycle when `wr_valid` is also high.
- `rd_data`  out  DATA_W  registered read beat.
- `rd_valid`  out  1  one-cycle pulse per read beat; no backpressure.
- `busy`  out  1  high in any state except IDLE.
- `mem_addr`  out  ADDR_W  to RAM address.
- `mem_data`  inout  DATA_W  to RAM data; driven only in WR_STROBE, else high-Z.
- `mem_we`  out  1  RAM write enable, active high.
- `mem_oe`  out  1  RAM output enable, active low.

## Operation

- States: IDLE, RD, WR_FETCH, WR_STROBE.
- IDLE: `req_ready`=1, `mem_oe`=1, `mem_we`=0, bus released. On `req_valid`: latch addr into `addr_q` and len into `cnt_q`; go to RD if `req_write`=0, else WR_FETCH.
- RD: `mem_addr`=`addr_q`, `mem_oe`=0. Each cycle, register `mem_data` into `rd_data` and assert `rd_valid` next cycle. If `cnt_q`==0 go to IDLE; else decrement `cnt_q`, increment `addr_q`, stay.
- WR_FETCH: `wr_ready`=1, `mem_oe`=1, `mem_we`=0. On `wr_valid`, latch `wr_data` and go to WR_STROBE. Otherwise stall indefinitely.
- WR_STROBE: drive `mem_data` from the latch, `mem_addr`=`addr_q`, `mem_we`=1 for exactly one cycle. If `cnt_q`==0 go to IDLE; else decrement, increment addr, go to WR_FETCH.
- Address increments modulo 2^ADDR_W: 15 → 0, no error.
- All `mem_*` outputs are registered or decoded from the state register only, never from inputs, so they are glitch-free.
- Bus contention rule: `mem_data` is never driven while `mem_oe`=0. IDLE always separates read and write bursts, giving at least one turnaround cycle.
- Ignored inputs:
  - `req_valid` while busy.
  - `wr_valid` outside WR_FETCH.
  - `req_len` and `req_addr` after acceptance.

## Timing

- Reset values: state IDLE, `req_ready`=1 (from the first cycle after reset), `busy`=0, `rd_valid`=0, `rd_data`=0, `mem_addr`=0, `mem_we`=0, `mem_oe`=1, `mem_data` high-Z, `wr_ready`=0.
- Reset mid-burst: takes effect at that edge. No `mem_we` strobe follows, and any pending `rd_valid` is dropped.
- Read latency: request accepted at edge E0. RD runs in cycles E0..E0+N (N beats). Beat k is on `rd_valid`/`rd_data` in the cycle after edge E0+1+k. The last beat appears while the controller is already in IDLE.
- Read throughput: one beat per cycle.
- Write throughput: two cycles per beat minimum (FETCH + STROBE). The RAM captures at the edge ending WR_STROBE.
- Back-to-back requests: a new request can be accepted in the first IDLE cycle after a burst. Minimum spacing is one IDLE cycle.

## Structure

- Shared package `cpu_pkg`:
  - state encoding localparams (IDLE=2'd0, RD=2'd1, WR_FETCH=2'd2, WR_STROBE=2'd3);
  - `ADDR_W`/`DATA_W` defaults shared with `ram`.
- One natural sub-module, `ram_burst_ctr`: loadable address register plus down-counter, with `load`, `step`, and a `last` flag (`cnt_q`==0).
- The tristate driver stays in the top level.

## Test plan

- Single write then read: write 0xA5 to addr 3, then read addr 3 → `rd_data`=0xA5 with one `rd_valid` pulse; `mem_we` high exactly one cycle.
- Burst wrap: write 4 beats 0x10..0x13 from addr 14 → RAM[14,15,0,1]=0x10..0x13. Read back len=3 from addr 14 → the same sequence on consecutive cycles.
- Write stall: hold `wr_valid`=0 for 5 cycles in WR_FETCH → `mem_we` stays 0, `busy`=1, `wr_ready`=1; the first valid beat is written correctly.
- Request during busy: pulse `req_valid` mid-read-burst → no acceptance (`req_ready`=0), burst completes unchanged.
- Reset mid-burst: assert `rst` on beat 2 of a 16-beat write → no further `mem_we`, all outputs at reset values next cycle, RAM words beyond beat 2 unchanged.
- Contention check (assertion): never `mem_oe`==0 while `mem_data` is driven by the controller, across random interleaved read/write bursts.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types and defaults for the CPU memory path: RAM
//               geometry and the ram_controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int RAM_ADDR_W = 4;  // 16 words
  localparam int RAM_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RD        = 2'd1,
    ST_WR_FETCH  = 2'd2,
    ST_WR_STROBE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ram_burst_ctr.sv
`default_nettype none
// ============================================================================
// Module      : ram_burst_ctr
// Description : Burst address register plus beat down-counter. A load takes
//               the start address and beat count (beats minus one); each step
//               advances the address (wrapping modulo 2^ADDR_W) and counts
//               down. o_last flags the final beat (count == 0).
// Ports       : clk, rst     - clock, synchronous active-high reset
//               i_load       - capture i_addr / i_len (wins over i_step)
//               i_step       - advance to the next beat
//               o_addr       - current beat address
//               o_last       - current beat is the last one
// Revision    : 1.0 - initial release
// ============================================================================
module ram_burst_ctr
  import cpu_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [ADDR_W-1:0] i_len,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_addr <= i_addr;
      r_cnt  <= i_len;
    end else if (i_step) begin
      r_addr <= r_addr + ADDR_W'(1);  // natural wrap 15 -> 0
      r_cnt  <= r_cnt - ADDR_W'(1);
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/ram_controller.sv
`default_nettype none
// ============================================================================
// Module      : ram_controller
// Description : Bus initiator for the 16x8 RAM. Accepts single/burst read or
//               write requests over valid/ready and sequences the RAM address,
//               bidirectional data bus, write enable and active-low output
//               enable. Owns the data-bus turnaround.
// Ports       : clk, rst                        - clock, sync active-high reset
//               i_req_valid/o_req_ready         - request handshake
//               i_req_write, i_req_addr, i_req_len - burst description
//               i_wr_data/i_wr_valid/o_wr_ready - write beat handshake
//               o_rd_data/o_rd_valid            - read beats, no backpressure
//               o_busy                          - not idle
//               o_mem_addr, io_mem_data, o_mem_we, o_mem_oe - RAM pins
// Revision    : 1.0 - initial release
// ============================================================================
module ram_controller
  import cpu_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [ADDR_W-1:0] i_req_len,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_mem_addr,
  inout  wire  [DATA_W-1:0] io_mem_data,
  output logic              o_mem_we,
  output logic              o_mem_oe
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_req_ready;
  logic              r_busy;
  logic              r_wr_ready;
  logic              r_mem_we;
  logic              r_mem_oe_n;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic [DATA_W-1:0] r_wr_data;

  logic              w_load;
  logic              w_step;
  logic              w_last;
  logic [ADDR_W-1:0] w_addr;

  // Only IDLE accepts requests; requests seen while busy are simply dropped.
  assign w_load = (r_state == ST_IDLE) && i_req_valid;
  // Address/count advance after every read cycle and every write strobe
  // except the final beat.
  assign w_step = ((r_state == ST_RD) || (r_state == ST_WR_STROBE)) && !w_last;

  ram_burst_ctr #(
    .ADDR_W (ADDR_W)
  ) u_burst_ctr (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_step (w_step),
    .i_addr (i_req_addr),
    .i_len  (i_req_len),
    .o_addr (w_addr),
    .o_last (w_last)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:      if (i_req_valid) w_state_nxt = i_req_write ? ST_WR_FETCH : ST_RD;
      ST_RD:        if (w_last)      w_state_nxt = ST_IDLE;
      ST_WR_FETCH:  if (i_wr_valid)  w_state_nxt = ST_WR_STROBE;
      ST_WR_STROBE: w_state_nxt = w_last ? ST_IDLE : ST_WR_FETCH;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  // Pin-level outputs are registered from the next-state value so they change
  // only on the clock edge, together with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_wr_ready  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_oe_n  <= 1'b1;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_wr_data   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= (w_state_nxt == ST_IDLE);
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_wr_ready  <= (w_state_nxt == ST_WR_FETCH);
      r_mem_we    <= (w_state_nxt == ST_WR_STROBE);
      r_mem_oe_n  <= (w_state_nxt != ST_RD);
      // Each RD cycle samples the RAM once; the beat is presented next cycle.
      r_rd_valid  <= (r_state == ST_RD);
      if (r_state == ST_RD) begin
        r_rd_data <= io_mem_data;
      end
      if ((r_state == ST_WR_FETCH) && i_wr_valid) begin
        r_wr_data <= i_wr_data;
      end
    end
  end

  // The bus is driven only during the write strobe, where output enable is
  // necessarily high, so the controller and the RAM never drive together.
  assign io_mem_data = r_mem_we ? r_wr_data : {DATA_W{1'bz}};

  assign o_req_ready = r_req_ready;
  assign o_busy      = r_busy;
  assign o_wr_ready  = r_wr_ready;
  assign o_rd_valid  = r_rd_valid;
  assign o_rd_data   = r_rd_data;
  assign o_mem_addr  = w_addr;
  assign o_mem_we    = r_mem_we;
  assign o_mem_oe    = r_mem_oe_n;

endmodule
`default_nettype wire

// File: tb/tb_ram_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_controller
// Description : Self-checking bench for ram_controller with a behavioural
//               16x8 RAM (asynchronous read, write on rising edge) and a
//               shadow copy of the expected RAM contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_write;
  logic [3:0] req_addr, req_len;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       req_ready, wr_ready, rd_valid, busy, mem_we, mem_oe;
  logic [7:0] rd_data;
  logic [3:0] mem_addr;
  wire  [7:0] mem_data;

  logic [7:0] ram    [16];
  logic [7:0] shadow [16];
  int         tests = 0;
  int         fails  = 0;
  int         we_cnt = 0;
  bit         chk_en = 1'b0;

  always #5 clk = ~clk;

  ram_controller dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_write (req_write),
    .i_req_addr  (req_addr),
    .i_req_len   (req_len),
    .i_wr_data   (wr_data),
    .i_wr_valid  (wr_valid),
    .o_wr_ready  (wr_ready),
    .o_rd_data   (rd_data),
    .o_rd_valid  (rd_valid),
    .o_busy      (busy),
    .o_mem_addr  (mem_addr),
    .io_mem_data (mem_data),
    .o_mem_we    (mem_we),
    .o_mem_oe    (mem_oe)
  );

  // Behavioural RAM
  assign mem_data = (!mem_oe) ? ram[mem_addr] : 8'bz;
  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_data;
      we_cnt <= we_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus contention monitor: a write strobe must never overlap output enable,
  // and while the RAM drives the bus the bus must carry exactly the RAM word.
  always @(negedge clk) begin
    if (chk_en) begin
      if (mem_we)  check("contention_we_oe", {31'd0, mem_oe}, 32'd1);
      if (!mem_oe) check("contention_bus", {24'd0, mem_data}, {24'd0, ram[mem_addr]});
    end
  end

  task automatic check_reset_vals();
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_rd_valid",  {31'd0, rd_valid},  32'd0);
    check("rst_rd_data",   {24'd0, rd_data},   32'd0);
    check("rst_mem_addr",  {28'd0, mem_addr},  32'd0);
    check("rst_mem_we",    {31'd0, mem_we},    32'd0);
    check("rst_mem_oe",    {31'd0, mem_oe},    32'd1);
    check("rst_wr_ready",  {31'd0, wr_ready},  32'd0);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [3:0] len,
                          input logic [7:0] base, input int stall);
    int         we0;
    logic [3:0] ad;
    check("wr_req_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_len = len;
    @(negedge clk);
    req_valid = 1'b0; req_addr = ~a; req_len = ~len;  // must be ignored now
    we0 = we_cnt;
    for (int k = 0; k <= int'(len); k++) begin
      ad = a + k[3:0];
      for (int s = 0; s < stall; s++) begin
        check("stall_wr_ready", {31'd0, wr_ready}, 32'd1);
        check("stall_we",       {31'd0, mem_we},   32'd0);
        check("stall_busy",     {31'd0, busy},     32'd1);
        @(negedge clk);
      end
      check("wr_ready", {31'd0, wr_ready}, 32'd1);
      wr_valid = 1'b1; wr_data = base + k[7:0];
      @(negedge clk);
      wr_valid = 1'b0; wr_data = 8'h00;
      check("strobe_we",   {31'd0, mem_we},   32'd1);
      check("strobe_addr", {28'd0, mem_addr}, {28'd0, ad});
      check("strobe_data", {24'd0, mem_data}, {24'd0, base + k[7:0]});
      shadow[ad] = base + k[7:0];
      @(negedge clk);
    end
    check("wr_end_busy",  {31'd0, busy}, 32'd0);
    check("wr_we_count",  32'(we_cnt - we0), 32'(int'(len) + 1));
  endtask

  task automatic do_read(input logic [3:0] a, input logic [3:0] len,
                         input logic [7:0] exp0, input bit poke);
    logic [3:0] ad;
    check("rd_req_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_len = len;
    @(negedge clk);
    req_valid = 1'b0; req_addr = ~a; req_len = 4'h0;
    check("rd_busy",      {31'd0, busy},     32'd1);
    check("rd_oe",        {31'd0, mem_oe},   32'd0);
    check("rd_no_beat",   {31'd0, rd_valid}, 32'd0);
    for (int k = 0; k <= int'(len); k++) begin
      @(negedge clk);
      ad = a + k[3:0];
      if (poke && k == 0) begin
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'h0; req_len = 4'h0;
        check("busy_req_ready", {31'd0, req_ready}, 32'd0);
      end
      if (poke && k == 1) req_valid = 1'b0;
      check("rd_valid", {31'd0, rd_valid}, 32'd1);
      check("rd_data",  {24'd0, rd_data},  {24'd0, shadow[ad]});
      if (k == 0) check("rd_first", {24'd0, rd_data}, {24'd0, exp0});
      if (k == int'(len)) check("rd_last_idle", {31'd0, req_ready}, 32'd1);
    end
    @(negedge clk);
    check("rd_end_valid", {31'd0, rd_valid},  32'd0);
    check("rd_end_ready", {31'd0, req_ready}, 32'd1);
  endtask

  typedef struct {
    bit         wr;
    logic [3:0] addr;
    logic [3:0] len;
    logic [7:0] base;
    int         stall;
    bit         poke;
    logic [7:0] exp0;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{wr: 1'b1, addr: 4'd3,  len: 4'd0, base: 8'hA5, stall: 0, poke: 1'b0, exp0: 8'h00};
    vecs[1] = '{wr: 1'b0, addr: 4'd3,  len: 4'd0, base: 8'h00, stall: 0, poke: 1'b0, exp0: 8'hA5};
    vecs[2] = '{wr: 1'b1, addr: 4'd14, len: 4'd3, base: 8'h10, stall: 0, poke: 1'b0, exp0: 8'h00};
    vecs[3] = '{wr: 1'b0, addr: 4'd14, len: 4'd3, base: 8'h00, stall: 0, poke: 1'b0, exp0: 8'h10};
    vecs[4] = '{wr: 1'b1, addr: 4'd7,  len: 4'd1, base: 8'h55, stall: 5, poke: 1'b0, exp0: 8'h00};
    vecs[5] = '{wr: 1'b0, addr: 4'd7,  len: 4'd2, base: 8'h00, stall: 0, poke: 1'b1, exp0: 8'h55};

    for (int i = 0; i < 16; i++) begin
      ram[i]    = 8'hE0 + 8'(i);
      shadow[i] = 8'hE0 + 8'(i);
    end
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 4'h0;
    req_len = 4'h0; wr_data = 8'h00; wr_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    check_reset_vals();

    // Directed vectors
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].len, vecs[i].base, vecs[i].stall);
      else            do_read(vecs[i].addr, vecs[i].len, vecs[i].exp0, vecs[i].poke);
    end
    check("ram_word14", {24'd0, ram[14]}, 32'h10);
    check("ram_word1",  {24'd0, ram[1]},  32'h13);

    // Reset during beat 2 of a 16-beat write from address 0
    begin
      int we0;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd0; req_len = 4'd15;
      @(negedge clk);
      req_valid = 1'b0;
      we0 = we_cnt;
      for (int k = 0; k < 2; k++) begin
        wr_valid = 1'b1; wr_data = 8'hC0 + k[7:0];
        @(negedge clk);
        wr_valid = 1'b0;
        shadow[k] = 8'hC0 + k[7:0];
        @(negedge clk);
      end
      wr_valid = 1'b1; wr_data = 8'hC2; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; wr_valid = 1'b0;
      check_reset_vals();
      repeat (2) @(negedge clk);
      check("rst_wr_we_count", 32'(we_cnt - we0), 32'd2);
      for (int i = 0; i < 16; i++) check("rst_wr_ram", {24'd0, ram[i]}, {24'd0, shadow[i]});
    end

    // Reset in the middle of a read burst drops the pending beat
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd0; req_len = 4'd15;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_rd_valid", {31'd0, rd_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals();

    // Random interleaved bursts (expected data from the shadow model)
    for (int n = 0; n < 16; n++) begin
      logic [3:0] a, l;
      a = 4'($urandom_range(0, 15));
      l = 4'($urandom_range(0, 5));
      if ($urandom_range(0, 1) == 1)
        do_write(a, l, 8'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
      else
        do_read(a, l, shadow[a], 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
